// File: rtl/mux21_bist.sv
// mux21_bist: built-in self-test sequencer for a 2:1 multiplexer.
// It applies all eight {sel, in} vectors to the mux. Each vector is held for
// SETTLE_CYCLES cycles and then checked for one cycle against the expected
// output. The results are a pass count, a per-vector fail mask and an
// all-pass flag.
module mux21_bist #(
  // Cycles each vector is held before the mux output is sampled; legal 1..255.
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       start,
  input  logic       abort,
  input  logic       mux_out,
  output logic [1:0] mux_in,
  output logic       mux_sel,
  output logic       busy,
  output logic       done,
  output logic       all_pass,
  output logic [7:0] pass_count,
  output logic [7:0] fail_vec
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] CHECK  = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  // Last settle count before the vector moves to CHECK.
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  logic [1:0] state;
  logic [2:0] idx;        // current vector, {sel, in[1], in[0]}
  logic [7:0] cnt;        // cycles spent so far in SETTLE for this vector
  logic       expBit;     // correct mux output for the current vector
  logic       lastVector;

  // Reference mux behaviour for the vector under test: sel picks in[1].
  assign expBit     = idx[2] ? idx[1] : idx[0];
  assign lastVector = (idx == 3'd7);

  // Sequencer state, vector index, settle counter and result registers.
  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples the values from before the edge, whatever the
  // statement order.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      idx        <= 3'd0;
      cnt        <= 8'd0;
      pass_count <= 8'd0;
      fail_vec   <= 8'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // A run begins from a clean slate, both from IDLE and from DONE.
          // abort is not sampled here, so start wins if both are high.
          if (start) begin
            state      <= SETTLE;
            idx        <= 3'd0;
            cnt        <= 8'd0;
            pass_count <= 8'd0;
            fail_vec   <= 8'd0;
          end
        end

        SETTLE: begin
          if (abort) begin
            state      <= IDLE;
            idx        <= 3'd0;
            cnt        <= 8'd0;
            pass_count <= 8'd0;
            fail_vec   <= 8'd0;
          end else begin
            cnt <= cnt + 8'd1;
            if (cnt == SETTLE_LAST) begin
              state <= CHECK;
            end
          end
        end

        CHECK: begin
          // abort outranks the result update made in the same cycle.
          if (abort) begin
            state      <= IDLE;
            idx        <= 3'd0;
            cnt        <= 8'd0;
            pass_count <= 8'd0;
            fail_vec   <= 8'd0;
          end else begin
            // At most eight increments, so the 8-bit count never saturates.
            if (mux_out == expBit) begin
              pass_count <= pass_count + 8'd1;
            end else begin
              fail_vec[idx] <= 1'b1;
            end
            if (lastVector) begin
              state <= DONE;
            end else begin
              idx   <= idx + 3'd1;
              cnt   <= 8'd0;
              state <= SETTLE;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Status flags and the vector driven onto the mux, decoded from state.
  // NOTE: every output gets a default before the case so that no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    mux_in   = 2'b00;
    mux_sel  = 1'b0;
    all_pass = 1'b0;
    case (state)
      SETTLE, CHECK: begin
        busy    = 1'b1;
        mux_sel = idx[2];
        mux_in  = idx[1:0];
      end
      DONE: begin
        done     = 1'b1;
        all_pass = (pass_count == 8'd8);
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mux21_bist.sv
// tb_mux21_bist: self-checking bench for mux21_bist.
// Instance A (SETTLE_CYCLES = 4) is attached to a mux model with selectable
// faults; instance B (SETTLE_CYCLES = 1) is attached to a correct mux.
module tb_mux21_bist;

  logic       CLK;
  logic       Reset;

  logic       startA, abortA, muxOutA;
  logic [1:0] muxInA;
  logic       muxSelA, busyA, doneA, allPassA;
  logic [7:0] passCountA, failVecA;

  logic       startB, abortB, muxOutB;
  logic [1:0] muxInB;
  logic       muxSelB, busyB, doneB, allPassB;
  logic [7:0] passCountB, failVecB;

  // Mux model mode: 0 correct, 1 stuck-at-0, 2 swapped select, 3 flip mask.
  int         muxMode;
  logic [7:0] flipMask;

  int nPass;
  int nTotal;

  mux21_bist #(.SETTLE_CYCLES(4)) dutA (
    .CLK(CLK), .Reset(Reset), .start(startA), .abort(abortA),
    .mux_out(muxOutA), .mux_in(muxInA), .mux_sel(muxSelA),
    .busy(busyA), .done(doneA), .all_pass(allPassA),
    .pass_count(passCountA), .fail_vec(failVecA)
  );

  mux21_bist #(.SETTLE_CYCLES(1)) dutB (
    .CLK(CLK), .Reset(Reset), .start(startB), .abort(abortB),
    .mux_out(muxOutB), .mux_in(muxInB), .mux_sel(muxSelB),
    .busy(busyB), .done(doneB), .all_pass(allPassB),
    .pass_count(passCountB), .fail_vec(failVecB)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Mux under test for instance A, with an optional planted fault.
  always_comb begin
    case (muxMode)
      1:       muxOutA = 1'b0;
      2:       muxOutA = muxSelA ? muxInA[0] : muxInA[1];
      3:       muxOutA = (muxSelA ? muxInA[1] : muxInA[0]) ^ flipMask[{muxSelA, muxInA}];
      default: muxOutA = muxSelA ? muxInA[1] : muxInA[0];
    endcase
  end

  assign muxOutB = muxSelB ? muxInB[1] : muxInB[0];

  // Truth table a good mux produces over vectors 7..0.
  localparam logic [7:0] GOOD_TABLE = 8'hCA;

  // Output table the faulty mux produces over vectors 7..0, from its behaviour.
  function automatic logic [7:0] observedTable(input int mode, input logic [7:0] mask);
    case (mode)
      1:       return 8'h00;
      2:       return 8'hAC;
      3:       return GOOD_TABLE ^ mask;
      default: return GOOD_TABLE;
    endcase
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    #7;
    nTotal++;
    if ({busyA, doneA, allPassA, muxSelA, muxInA, passCountA, failVecA} !== 21'd0) begin
      $display("FAIL reset_hold got=%h want=0",
               {busyA, doneA, allPassA, muxSelA, muxInA, passCountA, failVecA});
    end else nPass++;
    Reset = 1'b0;
    repeat (3) tick();
    nTotal++;
    if ({busyA, doneA, allPassA, muxSelA, muxInA, passCountA, failVecA,
         busyB, doneB, passCountB, failVecB} !== 39'd0) begin
      $display("FAIL idle_no_start got=%h want=0",
               {busyA, doneA, allPassA, muxSelA, muxInA, passCountA, failVecA});
    end else nPass++;
  endtask

  // Full run on instance A. glitchAt >= 0 pulses start mid-run at that cycle.
  // After completion an abort is applied in DONE and must be ignored.
  task automatic test_run(input string name, input int mode, input logic [7:0] mask,
                          input int glitchAt);
    logic [7:0] expFail;
    logic [7:0] expPass;
    muxMode  = mode;
    flipMask = mask;
    expFail  = GOOD_TABLE ^ observedTable(mode, mask);
    expPass  = 8'(8 - $countones(expFail));
    tick();
    startA = 1'b1;
    tick();                   // edge 0
    startA = 1'b0;
    for (int k = 0; k <= 41; k++) begin
      if (k > 0) tick();
      if (k < 40) begin
        nTotal++;
        if ({busyA, doneA, muxSelA, muxInA} !== {2'b10, 3'(k / 5)}) begin
          $display("FAIL %s_step k=%0d got=%b want=%b", name, k,
                   {busyA, doneA, muxSelA, muxInA}, {2'b10, 3'(k / 5)});
        end else nPass++;
      end
      if (k == 0) begin
        nTotal++;
        if ({passCountA, failVecA} !== 16'd0) begin
          $display("FAIL %s_clear got=%h want=0000", name, {passCountA, failVecA});
        end else nPass++;
      end
      if (k == 40) begin
        nTotal++;
        if ({busyA, doneA, muxSelA, muxInA, passCountA, failVecA, allPassA} !==
            {2'b01, 3'b000, expPass, expFail, expFail == 8'd0}) begin
          $display("FAIL %s_final done=%b pass=%0d fail=%h all=%b want pass=%0d fail=%h",
                   name, doneA, passCountA, failVecA, allPassA, expPass, expFail);
        end else nPass++;
      end
      if (k == 41) begin
        nTotal++;
        if ({doneA, passCountA, failVecA} !== {1'b1, expPass, expFail}) begin
          $display("FAIL %s_done_abort done=%b pass=%0d fail=%h want pass=%0d fail=%h",
                   name, doneA, passCountA, failVecA, expPass, expFail);
        end else nPass++;
      end
      startA = (k == glitchAt);
      abortA = (k == 40);
    end
    startA = 1'b0;
    abortA = 1'b0;
  endtask

  task automatic test_abort();
    muxMode = 0;
    tick();
    startA = 1'b1;
    tick();                   // edge 0
    startA = 1'b0;
    for (int k = 1; k <= 11; k++) tick();
    abortA = 1'b1;            // sampled at edge 12, inside vector 2
    tick();
    abortA = 1'b0;
    nTotal++;
    if ({busyA, doneA, muxSelA, muxInA, passCountA, failVecA} !== 21'd0) begin
      $display("FAIL abort_clear busy=%b done=%b vec=%b pass=%0d fail=%h want all 0",
               busyA, doneA, {muxSelA, muxInA}, passCountA, failVecA);
    end else nPass++;
    tick();
    nTotal++;
    if ({busyA, doneA} !== 2'b00) begin
      $display("FAIL abort_stays_idle got=%b want=00", {busyA, doneA});
    end else nPass++;
    // start and abort together in IDLE: start wins.
    startA = 1'b1;
    abortA = 1'b1;
    tick();
    startA = 1'b0;
    abortA = 1'b0;
    nTotal++;
    if ({busyA, muxSelA, muxInA} !== 4'b1000) begin
      $display("FAIL start_beats_abort got=%b want=1000", {busyA, muxSelA, muxInA});
    end else nPass++;
    abortA = 1'b1;            // abort during SETTLE of vector 0
    tick();
    abortA = 1'b0;
    nTotal++;
    if (busyA !== 1'b0) begin
      $display("FAIL abort_settle busy=%b want=0", busyA);
    end else nPass++;
  endtask

  task automatic test_reset_mid();
    muxMode = 0;
    tick();
    startA = 1'b1;
    tick();                   // edge 0
    startA = 1'b0;
    for (int k = 1; k <= 17; k++) tick();   // vector 3 in SETTLE, 3 passes so far
    nTotal++;
    if ({busyA, passCountA} !== {1'b1, 8'd3}) begin
      $display("FAIL pre_reset busy=%b pass=%0d want busy=1 pass=3", busyA, passCountA);
    end else nPass++;
    #2;
    Reset = 1'b1;
    #1;                       // still well before the next rising edge
    nTotal++;
    if ({busyA, doneA, muxSelA, muxInA, passCountA, failVecA} !== 21'd0) begin
      $display("FAIL async_reset busy=%b vec=%b pass=%0d want 0", busyA,
               {muxSelA, muxInA}, passCountA);
    end else nPass++;
    #1;
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_settle1();
    tick();
    startB = 1'b1;
    tick();                   // edge 0
    startB = 1'b0;
    for (int k = 0; k <= 16; k++) begin
      if (k > 0) tick();
      if (k < 16) begin
        nTotal++;
        if ({busyB, doneB, muxSelB, muxInB} !== {2'b10, 3'(k / 2)}) begin
          $display("FAIL settle1_step k=%0d got=%b want=%b", k,
                   {busyB, doneB, muxSelB, muxInB}, {2'b10, 3'(k / 2)});
        end else nPass++;
      end else begin
        nTotal++;
        if ({doneB, passCountB, failVecB, allPassB} !== {1'b1, 8'd8, 8'd0, 1'b1}) begin
          $display("FAIL settle1_final done=%b pass=%0d fail=%h all=%b want 1/8/00/1",
                   doneB, passCountB, failVecB, allPassB);
        end else nPass++;
      end
    end
  endtask

  initial begin
    nPass    = 0;
    nTotal   = 0;
    muxMode  = 0;
    flipMask = 8'd0;
    startA   = 1'b0;
    abortA   = 1'b0;
    startB   = 1'b0;
    abortB   = 1'b0;
    test_reset();
    test_run("good", 0, 8'h00, -1);
    test_run("stuck0", 1, 8'h00, -1);
    test_run("swapped", 2, 8'h00, -1);
    test_run("rerun_glitch", 0, 8'h00, 17);
    test_abort();
    test_reset_mid();
    for (int r = 0; r < 5; r++) begin
      int unsigned mode;
      logic [7:0]  mask;
      int          glitch;
      mode   = $urandom_range(0, 3);
      mask   = 8'($urandom);
      glitch = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 38)) : -1;
      test_run($sformatf("rand%0d", r), int'(mode), mask, glitch);
    end
    test_settle1();
    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule
